// File: rtl/shift_cmd_issuer_if.sv
// Handshake and shifter-side bus of the shift command issuer.
// The slave modport is the issuer. The master modport is the producer,
// consumer and shifter stub that surround it.
interface shift_cmd_issuer_if #(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic [CTRL_W-1:0] cmd_amt;
    logic [DATA_W-1:0] sh_in;
    logic [CTRL_W-1:0] sh_ctrl;
    logic [DATA_W-1:0] sh_out;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [CTRL_W-1:0] res_amt;
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_data, cmd_amt, sh_out, res_ready,
        output cmd_ready, sh_in, sh_ctrl, res_valid, res_data, res_amt, busy
    );

    modport master (
        output cmd_valid, cmd_data, cmd_amt, sh_out, res_ready,
        input  cmd_ready, sh_in, sh_ctrl, res_valid, res_data, res_amt, busy
    );
endinterface

// File: rtl/shift_cmd_issuer.sv
// Command stage in front of the combinational barrel shifter.
// Commands are queued in a small FIFO. They are driven into the shifter
// from registers, and the shifter output is captured one cycle later.
// Optional feature macro SHIFT_ZERO_BYPASS_EN: when it is defined, an
// amount-0 command skips the shifter. Its data goes straight into the
// result register at the pop edge.
module shift_cmd_issuer #(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_cmd_issuer_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t            state;
    state_t            next_state;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [CTRL_W-1:0] amt_mem  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_amt;
    logic              cmd_ready;
    logic              push;
    logic              pop;
    logic              pop_zero;
    logic              pop_drive;
    logic              load_sh;
    logic              capture;

    logic [DATA_W-1:0] sh_in;
    logic [CTRL_W-1:0] sh_ctrl;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [CTRL_W-1:0] res_amt;

    assign cmd_ready = (count != FULL_COUNT);
    assign push      = bus.cmd_valid && cmd_ready;
    assign head_data = data_mem[rd_ptr];
    assign head_amt  = amt_mem[rd_ptr];
    assign pop       = (state == IDLE) && (count != '0) && (!res_valid || bus.res_ready);

`ifdef SHIFT_ZERO_BYPASS_EN
    assign pop_zero  = pop && (head_amt == '0);
`else
    assign pop_zero  = 1'b0;
`endif
    assign pop_drive = pop && !pop_zero;

    // FIFO storage; only the pointers need reset, stale entries are never read
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= bus.cmd_data;
            amt_mem[wr_ptr]  <= bus.cmd_amt;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !push) count <= count - (PTR_W+1)'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // FSM next state: DRIVE is always a single cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pop_drive) next_state = DRIVE;
            DRIVE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: load the shifter operands on a normal pop, capture its result in DRIVE
    always_comb begin
        load_sh = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE:    load_sh = pop_drive;
            DRIVE:   capture = 1'b1;
            default: ;
        endcase
    end

    // Shifter operand registers hold their value until the next normal pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_in   <= '0;
            sh_ctrl <= '0;
        end else if (load_sh) begin
            sh_in   <= head_data;
            sh_ctrl <= head_amt;
        end
    end

    // Result register: a capture beats a consume on the same edge, and data is frozen while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_amt   <= '0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_data  <= bus.sh_out;
            res_amt   <= sh_ctrl;
        end else if (pop_zero) begin
            res_valid <= 1'b1;
            res_data  <= head_data;
            res_amt   <= head_amt;
        end else if (res_valid && bus.res_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.sh_in     = sh_in;
    assign bus.sh_ctrl   = sh_ctrl;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_amt   = res_amt;
    assign bus.busy      = (count != '0) || (state == DRIVE) || res_valid;
endmodule

// File: tb/tb_shift_cmd_issuer.sv
// Self-checking bench for shift_cmd_issuer. The shifter is stubbed as sh_out = ~sh_in.
// The bench is aware of the SHIFT_ZERO_BYPASS_EN build option.
module tb_shift_cmd_issuer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    shift_cmd_issuer_if #(.DATA_W(8), .CTRL_W(3)) bus ();

    assign bus.sh_out = ~bus.sh_in;

    shift_cmd_issuer #(.DATA_W(8), .CTRL_W(3), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        logic [7:0] expData;
        logic [2:0] expAmt;
    } vec_t;

    vec_t       vecs [10];
    int         checks = 0;
    int         passes = 0;
    logic [10:0] expQ [$];

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Offer one command and queue its expected result once it is accepted
    task automatic applyStimulus(input logic [7:0] d, input logic [2:0] a, input logic [7:0] ed, input logic [2:0] ea);
        int  waited = 0;
        bit  done = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_amt   = a;
        while (!done && waited < 50) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                expQ.push_back({ed, ea});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        bus.cmd_valid = 1'b0;
        if (!done) checkOutput("push_timeout", 32'd0, 32'd1);
    endtask

    // Wait, with a bound, until every expected result has come out and the block is idle
    task automatic waitDrain(input string name);
        int n = 0;
        while ((expQ.size() != 0 || bus.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, (expQ.size() == 0 && !bus.busy)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every result handshake is checked against the oldest expected entry
    always @(negedge clk) begin : monitor
        logic [10:0] exp;
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", {24'd0, bus.res_data}, 32'hFFFF_FFFF);
            end else begin
                exp = expQ.pop_front();
                checkOutput("res_data", {24'd0, bus.res_data}, {24'd0, exp[10:3]});
                checkOutput("res_amt", {29'd0, bus.res_amt}, {29'd0, exp[2:0]});
            end
        end
    end

    initial begin
        logic [7:0] shPrev;
        logic [7:0] zeroExp;
        bit         staleSeen;

        vecs[0] = '{8'h3C, 3'd1, 8'hC3, 3'd1};
        vecs[1] = '{8'hA5, 3'd2, 8'h5A, 3'd2};
        vecs[2] = '{8'h0F, 3'd3, 8'hF0, 3'd3};
        vecs[3] = '{8'h81, 3'd4, 8'h7E, 3'd4};
        vecs[4] = '{8'h12, 3'd5, 8'hED, 3'd5};
        vecs[5] = '{8'h77, 3'd6, 8'h88, 3'd6};
        vecs[6] = '{8'hC0, 3'd7, 8'h3F, 3'd7};
        vecs[7] = '{8'h5B, 3'd1, 8'hA4, 3'd1};
        vecs[8] = '{8'h02, 3'd2, 8'hFD, 3'd2};
        vecs[9] = '{8'h69, 3'd3, 8'h96, 3'd3};

        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_amt   = '0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        checkOutput("rst_sh_in", {24'd0, bus.sh_in}, 32'd0);
        checkOutput("rst_sh_ctrl", {29'd0, bus.sh_ctrl}, 32'd0);
        checkOutput("rst_res_data", {24'd0, bus.res_data}, 32'd0);
        checkOutput("rst_res_amt", {29'd0, bus.res_amt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);

        // Single command latency
        bus.res_ready = 1'b1;
        applyStimulus(8'h80, 3'd4, 8'h7F, 3'd4);
        @(negedge clk);
        checkOutput("single_n_sh_in", {24'd0, bus.sh_in}, 32'd0);
        checkOutput("single_n_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        checkOutput("single_n1_sh_in", {24'd0, bus.sh_in}, 32'h80);
        checkOutput("single_n1_sh_ctrl", {29'd0, bus.sh_ctrl}, 32'd4);
        checkOutput("single_n1_res_valid", {31'd0, bus.res_valid}, 32'd0);
        @(negedge clk);
        checkOutput("single_n2_res_valid", {31'd0, bus.res_valid}, 32'd1);
        checkOutput("single_n2_res_data", {24'd0, bus.res_data}, 32'h7F);
        checkOutput("single_n2_res_amt", {29'd0, bus.res_amt}, 32'd4);
        waitDrain("single_drain");

        // Fill and back-pressure
        bus.res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] d;
            d = 8'(i);
            applyStimulus(d, 3'd1, ~d, 3'd1);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'h06;
        bus.cmd_amt   = 3'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("fill_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            checkOutput("fill_res_valid", {31'd0, bus.res_valid}, 32'd1);
            checkOutput("fill_hold_data", {24'd0, bus.res_data}, 32'hFE);
            checkOutput("fill_count", {29'd0, dut.count}, 32'd4);
            @(posedge clk);
            #1;
        end
        bus.res_ready = 1'b1;
        applyStimulus(8'h06, 3'd1, 8'hF9, 3'd1);
        waitDrain("fill_drain");

        // Simultaneous push and pop at count 2
        bus.res_ready = 1'b0;
        applyStimulus(8'h21, 3'd2, 8'hDE, 3'd2);
        applyStimulus(8'h22, 3'd2, 8'hDD, 3'd2);
        applyStimulus(8'h23, 3'd2, 8'hDC, 3'd2);
        @(negedge clk);
        checkOutput("simul_count_before", {29'd0, dut.count}, 32'd2);
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        applyStimulus(8'h24, 3'd2, 8'hDB, 3'd2);
        @(negedge clk);
        checkOutput("simul_count_after", {29'd0, dut.count}, 32'd2);
        waitDrain("simul_drain");

        // Table-driven run, long enough to wrap the FIFO pointers several times
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].data, vecs[i].amt, vecs[i].expData, vecs[i].expAmt);
        end
        waitDrain("table_drain");

        // Zero shift amount
        shPrev = bus.sh_in;
`ifdef SHIFT_ZERO_BYPASS_EN
        zeroExp = 8'hFF;
`else
        zeroExp = 8'h00;
`endif
        applyStimulus(8'hFF, 3'd0, zeroExp, 3'd0);
        @(negedge clk);
        checkOutput("zero_n_res_valid", {31'd0, bus.res_valid}, 32'd0);
        @(negedge clk);
`ifdef SHIFT_ZERO_BYPASS_EN
        checkOutput("zero_n1_res_valid", {31'd0, bus.res_valid}, 32'd1);
        checkOutput("zero_n1_res_data", {24'd0, bus.res_data}, 32'hFF);
        checkOutput("zero_n1_sh_in", {24'd0, bus.sh_in}, {24'd0, shPrev});
`else
        checkOutput("zero_n1_res_valid", {31'd0, bus.res_valid}, 32'd0);
        checkOutput("zero_n1_sh_in", {24'd0, bus.sh_in}, 32'hFF);
        checkOutput("zero_n1_sh_ctrl", {29'd0, bus.sh_ctrl}, 32'd0);
        @(negedge clk);
        checkOutput("zero_n2_res_valid", {31'd0, bus.res_valid}, 32'd1);
        checkOutput("zero_n2_res_data", {24'd0, bus.res_data}, 32'h00);
`endif
        waitDrain("zero_drain");

        // Reset mid-stream with commands queued and a result pending
        bus.res_ready = 1'b0;
        applyStimulus(8'h11, 3'd2, 8'hEE, 3'd2);
        applyStimulus(8'h22, 3'd2, 8'hDD, 3'd2);
        applyStimulus(8'h33, 3'd2, 8'hCC, 3'd2);
        applyStimulus(8'h44, 3'd2, 8'hBB, 3'd2);
        @(negedge clk);
        checkOutput("mid_pre_res_valid", {31'd0, bus.res_valid}, 32'd1);
        checkOutput("mid_pre_count", {29'd0, dut.count}, 32'd3);
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("mid_res_valid", {31'd0, bus.res_valid}, 32'd0);
        checkOutput("mid_sh_in", {24'd0, bus.sh_in}, 32'd0);
        checkOutput("mid_sh_ctrl", {29'd0, bus.sh_ctrl}, 32'd0);
        checkOutput("mid_res_data", {24'd0, bus.res_data}, 32'd0);
        checkOutput("mid_res_amt", {29'd0, bus.res_amt}, 32'd0);
        checkOutput("mid_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        bus.res_ready = 1'b1;
        staleSeen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.res_valid || bus.busy) staleSeen = 1'b1;
        end
        checkOutput("mid_no_stale", {31'd0, staleSeen}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
